ensemble_vote_ctrl: RTL and testbench
=====================================

// Module: ensemble_vote_ctrl
// PURPOSE
//   Sequencer and voter for the three-classifier ensemble (gaussian_nb, gradient_boost, mlp).
//   - Takes one feature vector from a single upstream AXI-Stream.
//   - Broadcasts each word lock-step to all three classifiers.
//   - Collects one result word per classifier and forms a 2-of-3 majority vote.
//   - Emits one status+class word downstream.
//   - Sits between the DMA stream and the classifier wrapper.
// PARAMETERS
//   DATA_WIDTH      32    stream word width, all interfaces
//   KEEP_WIDTH      4     tkeep width
//   NUM_FEATURES    16    words per sample (>=1)
//   CLASS_WIDTH     8     low bits of a result word taken as class label (<= DATA_WIDTH-8)
//   TIMEOUT_CYCLES  4096  max cycles spent in COLLECT
// PORTS
//   clk             in   1           clock
//   rst_n           in   1           asynchronous active-low reset
//   s_axis_tdata    in   DATA_WIDTH  upstream feature word
//   s_axis_tkeep    in   KEEP_WIDTH  upstream keep
//   s_axis_tvalid   in   1           upstream valid
//   s_axis_tready   out  1           upstream ready
//   s_axis_tlast    in   1           upstream last (checked only)
//   clf_tdata_k     out  DATA_WIDTH  k=1..3: broadcast word to classifier k (= s_axis_tdata)
//   clf_tkeep_k     out  KEEP_WIDTH  k=1..3: = s_axis_tkeep
//   clf_tvalid_k    out  1           k=1..3: valid to classifier k
//   clf_tready_k    in   1           k=1..3: ready from classifier k
//   clf_tlast_k     out  1           k=1..3: high on word NUM_FEATURES-1
//   res_tdata_k     in   DATA_WIDTH  k=1..3: result word from classifier k
//   res_tvalid_k    in   1           k=1..3: result valid
//   res_tready_k    out  1           k=1..3: result ready
//   res_tlast_k     in   1           k=1..3: ignored
//   m_axis_tdata    out  DATA_WIDTH  vote word (format below)
//   m_axis_tkeep    out  KEEP_WIDTH  all ones
//   m_axis_tvalid   out  1           vote valid
//   m_axis_tready   in   1           downstream ready
//   m_axis_tlast    out  1           constant 1 (one-word packet)
//   err_timeout     out  1           sticky; set on any COLLECT timeout, cleared only by reset
// BEHAVIOUR
//   Reset
//     - rst_n low: state=FEED, word_cnt=0, acc[3:1]=0, got[3:1]=0, flags=0, err_timeout=0.
//     - All tvalid/tready outputs forced 0 while rst_n low.
//     - Reset mid-operation discards the partial sample; the classifiers share rst_n.
//   FEED (broadcast)
//     - clf_tvalid_k = s_axis_tvalid & ~acc[k].
//     - acc[k] sets on a clf k handshake.
//     - s_axis_tready = &(acc | clf_tready); the upstream handshake clears acc.
//     - Each word reaches each classifier exactly once, combinationally (0 latency).
//     - word_cnt increments per upstream handshake.
//     - len_err sets if s_axis_tlast != (word_cnt==NUM_FEATURES-1).
//     - Handshake with word_cnt==NUM_FEATURES-1: word_cnt<=0, go to COLLECT.
//   COLLECT
//     - res_tready_k = ~got[k]. Handshake: got[k]<=1, cls[k]<=res_tdata_k[CLASS_WIDTH-1:0].
//     - s_axis_tready=0; res_tready_k=0 in all states other than COLLECT.
//     - tmo_cnt counts cycles in COLLECT.
//     - &got -> VOTE. tmo_cnt==TIMEOUT_CYCLES-1 -> VOTE, timeout<=1, err_timeout<=1.
//     - All-got wins over timeout in the same cycle.
//     - After a timeout, late results stay un-accepted and pollute the next sample; recovery is reset.
//   VOTE (1 cycle)
//     - Valid votes: those with got[k]=1.
//     - >=2 valid equal -> that class; unanimous=1 iff all 3 valid and equal.
//     - 3 valid, all distinct -> cls[1], tie=1.
//     - Exactly 1 valid -> that class.
//     - 0 valid -> class 0.
//     - Next state EMIT.
//   EMIT
//     - m_axis_tvalid=1, held with data stable until m_axis_tready.
//     - On handshake: clear got, flags, tmo_cnt; return to FEED.
//   Output word
//     - [CLASS_WIDTH-1:0] = class.
//     - [DATA_WIDTH-1 -: 8] = {0, len_err, timeout, tie, unanimous, got[3], got[2], got[1]}.
//     - All other bits 0.
//   Latency
//     - m_axis_tvalid rises on the 2nd clk edge after the last result handshake.
//   Registers
//     - State, acc, got, cls, counters and flags are registered.
//     - Broadcast valid/ready paths are combinational from those registers.
// TESTING
//   T1: 16 words; results 5,5,5 -> class=5, unanimous=1, got=111, tlast=1; tvalid 2 cycles after last result.
//   T2: results 3,3,7 -> class=3, unanimous=0, tie=0. Results 3,7,7 -> class=7.
//   T3: results 1,2,4 -> class=1, tie=1, got=111.
//   T4: random 50% low clf_tready_2 and random s_axis_tvalid gaps -> each classifier sees 16 words,
//       in order, no duplicates, tlast only on word 15.
//   T5: classifier 3 silent, results 9,9 -> VOTE at TIMEOUT_CYCLES, class=9, timeout=1,
//       got=011, err_timeout stays 1.
//   T6: s_axis_tlast on word 9 -> len_err=1. Separately, rst_n pulse mid-FEED (word 6)
//       -> all valids 0 during reset; the next full sample votes correctly with len_err=0.

Source files
------------

// File: rtl/ensemble_vote_ctrl.sv
// ensemble_vote_ctrl
//   Sequencer and 2-of-3 majority voter for a three-classifier ensemble.
//   One feature vector (NUM_FEATURES words) is taken from the upstream
//   stream and broadcast lock-step to three classifiers. One result word is
//   then collected from each classifier. The vote is formed and emitted as a
//   single status+class word.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_*                   upstream feature stream (tlast is only checked)
//   clf_*_1..3                 broadcast streams to the classifiers
//   res_*_1..3                 result streams from the classifiers (tlast ignored)
//   m_axis_*                   one-word vote packet
//   err_timeout                sticky COLLECT-timeout flag, cleared by reset only
// Vote word: [CLASS_WIDTH-1:0] = class,
//            [DATA_WIDTH-1 -: 8] = {0, len_err, timeout, tie, unanimous, got[3:1]}
module ensemble_vote_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = 4,
  parameter int NUM_FEATURES   = 16,
  parameter int CLASS_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] clf_tdata_1,
  output logic [KEEP_WIDTH-1:0] clf_tkeep_1,
  output logic                  clf_tvalid_1,
  input  logic                  clf_tready_1,
  output logic                  clf_tlast_1,
  output logic [DATA_WIDTH-1:0] clf_tdata_2,
  output logic [KEEP_WIDTH-1:0] clf_tkeep_2,
  output logic                  clf_tvalid_2,
  input  logic                  clf_tready_2,
  output logic                  clf_tlast_2,
  output logic [DATA_WIDTH-1:0] clf_tdata_3,
  output logic [KEEP_WIDTH-1:0] clf_tkeep_3,
  output logic                  clf_tvalid_3,
  input  logic                  clf_tready_3,
  output logic                  clf_tlast_3,
  input  logic [DATA_WIDTH-1:0] res_tdata_1,
  input  logic                  res_tvalid_1,
  output logic                  res_tready_1,
  input  logic                  res_tlast_1,
  input  logic [DATA_WIDTH-1:0] res_tdata_2,
  input  logic                  res_tvalid_2,
  output logic                  res_tready_2,
  input  logic                  res_tlast_2,
  input  logic [DATA_WIDTH-1:0] res_tdata_3,
  input  logic                  res_tvalid_3,
  output logic                  res_tready_3,
  input  logic                  res_tlast_3,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  err_timeout
);

  localparam int CNT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_FEATURES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_FEED, ST_COLLECT, ST_VOTE, ST_EMIT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [2:0]             acc_q, acc_d;
  logic [2:0]             got_q, got_d;
  logic [CLASS_WIDTH-1:0] cls_q [3];
  logic [CLASS_WIDTH-1:0] cls_d [3];
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic len_err_q, len_err_d, timeout_q, timeout_d, tie_q, tie_d, unan_q, unan_d;
  logic err_timeout_q, err_timeout_d;

  // Per-classifier views of the scalar ports, index 0..2 = classifier 1..3.
  logic [2:0]            clf_tready_v, clf_tvalid_v, clf_hs;
  logic [2:0]            res_tvalid_v, res_tready_v, res_hs;
  logic [DATA_WIDTH-1:0] res_tdata_v [3];
  logic                  in_feed, in_collect, last_word, up_hs;
  logic                  unused_in;

  assign clf_tready_v   = {clf_tready_3, clf_tready_2, clf_tready_1};
  assign res_tvalid_v   = {res_tvalid_3, res_tvalid_2, res_tvalid_1};
  assign res_tdata_v[0] = res_tdata_1;
  assign res_tdata_v[1] = res_tdata_2;
  assign res_tdata_v[2] = res_tdata_3;
  assign unused_in = ^{res_tlast_1, res_tlast_2, res_tlast_3,
                       res_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                       res_tdata_2[DATA_WIDTH-1:CLASS_WIDTH],
                       res_tdata_3[DATA_WIDTH-1:CLASS_WIDTH]};

  // Handshake outputs are gated by rst_n so they read 0 while reset is held,
  // even though an upstream valid may already be present.
  assign in_feed    = rst_n && (state_q == ST_FEED);
  assign in_collect = rst_n && (state_q == ST_COLLECT);
  assign last_word  = (word_cnt_q == LAST_WORD);

  // acc marks classifiers that already took the current word, so each word
  // reaches each classifier once while the slower ones catch up.
  assign clf_tvalid_v  = {3{in_feed & s_axis_tvalid}} & ~acc_q;
  assign clf_hs        = clf_tvalid_v & clf_tready_v;
  assign s_axis_tready = in_feed & (&(acc_q | clf_tready_v));
  assign up_hs         = s_axis_tvalid & s_axis_tready;
  assign res_tready_v  = {3{in_collect}} & ~got_q;
  assign res_hs        = res_tvalid_v & res_tready_v;

  assign {clf_tvalid_3, clf_tvalid_2, clf_tvalid_1} = clf_tvalid_v;
  assign {res_tready_3, res_tready_2, res_tready_1} = res_tready_v;
  assign clf_tdata_1 = s_axis_tdata;
  assign clf_tdata_2 = s_axis_tdata;
  assign clf_tdata_3 = s_axis_tdata;
  assign clf_tkeep_1 = s_axis_tkeep;
  assign clf_tkeep_2 = s_axis_tkeep;
  assign clf_tkeep_3 = s_axis_tkeep;
  assign clf_tlast_1 = last_word;
  assign clf_tlast_2 = last_word;
  assign clf_tlast_3 = last_word;

  assign m_axis_tvalid = rst_n && (state_q == ST_EMIT);
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = 1'b1;
  assign err_timeout   = err_timeout_q;

  always_comb begin
    m_axis_tdata                      = '0;
    m_axis_tdata[CLASS_WIDTH-1:0]     = class_q;
    m_axis_tdata[DATA_WIDTH-1 -: 8]   = {1'b0, len_err_q, timeout_q, tie_q, unan_q, got_q};
  end

  // Majority vote over the results that actually arrived.
  logic                   e12, e13, e23;
  logic [CLASS_WIDTH-1:0] vote_cls;
  logic                   vote_tie, vote_unan;

  assign e12 = got_q[0] & got_q[1] & (cls_q[0] == cls_q[1]);
  assign e13 = got_q[0] & got_q[2] & (cls_q[0] == cls_q[2]);
  assign e23 = got_q[1] & got_q[2] & (cls_q[1] == cls_q[2]);

  always_comb begin
    vote_cls  = '0;
    vote_tie  = 1'b0;
    vote_unan = (&got_q) & e12 & e23;
    if (e12 || e13)    vote_cls = cls_q[0];
    else if (e23)      vote_cls = cls_q[1];
    else if (&got_q) begin
      vote_cls = cls_q[0];
      vote_tie = 1'b1;
    end
    // Fewer than three votes and no agreement: lowest-numbered arrival wins.
    else if (got_q[0]) vote_cls = cls_q[0];
    else if (got_q[1]) vote_cls = cls_q[1];
    else if (got_q[2]) vote_cls = cls_q[2];
  end

  // NOTE: every _d is given its hold value first, so no path through the
  // case below leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    acc_d         = acc_q;
    got_d         = got_q;
    cls_d         = cls_q;
    class_d       = class_q;
    len_err_d     = len_err_q;
    timeout_d     = timeout_q;
    tie_d         = tie_q;
    unan_d        = unan_q;
    err_timeout_d = err_timeout_q;

    unique case (state_q)
      ST_FEED: begin
        acc_d = acc_q | clf_hs;
        if (up_hs) begin
          acc_d = '0;
          if (s_axis_tlast != last_word) len_err_d = 1'b1;
          if (last_word) begin
            word_cnt_d = '0;
            state_d    = ST_COLLECT;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        for (int k = 0; k < 3; k++) begin
          if (res_hs[k]) begin
            got_d[k] = 1'b1;
            cls_d[k] = res_tdata_v[k][CLASS_WIDTH-1:0];
          end
        end
        if (&got_q) begin
          state_d = ST_VOTE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // A last result arriving on the expiry cycle still wins: stay one
          // more cycle and leave through the all-got path instead.
          if (!(&got_d)) begin
            state_d       = ST_VOTE;
            timeout_d     = 1'b1;
            err_timeout_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_VOTE: begin
        class_d = vote_cls;
        tie_d   = vote_tie;
        unan_d  = vote_unan;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (m_axis_tready) begin
          got_d     = '0;
          len_err_d = 1'b0;
          timeout_d = 1'b0;
          tie_d     = 1'b0;
          unan_d    = 1'b0;
          tmo_cnt_d = '0;
          state_d   = ST_FEED;
        end
      end
      default: state_d = ST_FEED;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FEED;
      word_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      acc_q         <= '0;
      got_q         <= '0;
      cls_q         <= '{default: '0};
      class_q       <= '0;
      len_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
      tie_q         <= 1'b0;
      unan_q        <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      acc_q         <= acc_d;
      got_q         <= got_d;
      cls_q         <= cls_d;
      class_q       <= class_d;
      len_err_q     <= len_err_d;
      timeout_q     <= timeout_d;
      tie_q         <= tie_d;
      unan_q        <= unan_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_ensemble_vote_ctrl.sv
// tb_ensemble_vote_ctrl
//   Directed bench for ensemble_vote_ctrl: a table of samples (results per
//   classifier, expected vote word) plus hand sequences for reset behaviour.
//   Inputs are driven 1 time unit after posedge; outputs sampled at negedge.
module tb_ensemble_vote_ctrl;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int NF  = 16;
  localparam int CW  = 8;
  localparam int TMO = 64;

  typedef struct {
    int             tlast_pos;
    bit             gaps;
    bit             rnd;
    bit [2:0]       en;
    logic [2:0][7:0] cls;
    logic [7:0]     exp_cls;
    logic [7:0]     exp_top;
    bit             exp_err;
  } vec_t;

  logic          clk, rst_n;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] clf_tdata [3];
  logic [KW-1:0] clf_tkeep [3];
  logic [2:0]    clf_tvalid, clf_tready, clf_tlast;
  logic [DW-1:0] res_tdata [3];
  logic [2:0]    res_tvalid, res_tready, res_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast, err_timeout;

  int   total, bad, cyc;
  bit   rnd_mode;
  logic [36:0] rxq [3][$];
  vec_t vecs [8];

  ensemble_vote_ctrl #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_FEATURES(NF),
    .CLASS_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .clf_tdata_1(clf_tdata[0]), .clf_tkeep_1(clf_tkeep[0]), .clf_tvalid_1(clf_tvalid[0]),
    .clf_tready_1(clf_tready[0]), .clf_tlast_1(clf_tlast[0]),
    .clf_tdata_2(clf_tdata[1]), .clf_tkeep_2(clf_tkeep[1]), .clf_tvalid_2(clf_tvalid[1]),
    .clf_tready_2(clf_tready[1]), .clf_tlast_2(clf_tlast[1]),
    .clf_tdata_3(clf_tdata[2]), .clf_tkeep_3(clf_tkeep[2]), .clf_tvalid_3(clf_tvalid[2]),
    .clf_tready_3(clf_tready[2]), .clf_tlast_3(clf_tlast[2]),
    .res_tdata_1(res_tdata[0]), .res_tvalid_1(res_tvalid[0]), .res_tready_1(res_tready[0]),
    .res_tlast_1(res_tlast[0]),
    .res_tdata_2(res_tdata[1]), .res_tvalid_2(res_tvalid[1]), .res_tready_2(res_tready[1]),
    .res_tlast_2(res_tlast[1]),
    .res_tdata_3(res_tdata[2]), .res_tvalid_3(res_tvalid[2]), .res_tready_3(res_tready[2]),
    .res_tlast_3(res_tlast[2]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // Classifier 2 may throttle randomly; 1 and 3 are always ready.
  initial begin
    clf_tready = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      clf_tready[1] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Record every word each classifier accepts.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++)
          if (clf_tvalid[k] && clf_tready[k])
            rxq[k].push_back({clf_tlast[k], clf_tkeep[k], clf_tdata[k]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer nwords upstream words starting at base; returns the cycle number of
  // the edge that took the final word.
  task automatic feed(input int nwords, input int tlast_pos, input bit gaps,
                      input logic [31:0] base, output int last_cyc);
    bit hs;
    last_cyc = 0;
    for (int w = 0; w < nwords; w++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tdata  = base + 32'(w);
      s_tkeep  = 4'(w);
      s_tlast  = (w == tlast_pos);
      s_tvalid = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 100 && !hs; t++) begin
        @(negedge clk);
        if (s_tready) begin
          hs = 1'b1;
          last_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
      end
      if (!hs) begin
        check("feed_handshake", 0, 1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Present results (upper bits deliberately non-zero); returns the cycle of
  // the edge that took the last one.
  task automatic drive_results(input bit [2:0] en, input logic [2:0][7:0] cls,
                               output int hs_cyc);
    bit [2:0] done;
    done   = '0;
    hs_cyc = 0;
    for (int k = 0; k < 3; k++) res_tdata[k] = {24'hA5A5A5, cls[k]};
    for (int t = 0; t < 100 && done != en; t++) begin
      res_tvalid = en & ~done;
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (res_tvalid[k] && res_tready[k]) begin
          done[k] = 1'b1;
          hs_cyc  = cyc + 1;
        end
      @(posedge clk);
      #1;
    end
    res_tvalid = '0;
    check("result_handshake", done, en);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int ec, hc, vc, nerr;
    bit seen;
    logic [31:0] base, exp_word;
    logic [36:0] exp_rx;
    seen = 1'b0;
    vc   = 0;
    base = 32'h1000 * (id + 1);
    for (int k = 0; k < 3; k++) rxq[k].delete();
    rnd_mode = v.rnd;
    feed(NF, v.tlast_pos, v.gaps, base, ec);
    rnd_mode = 1'b0;
    drive_results(v.en, v.cls, hc);
    exp_word = {v.exp_top, 16'h0000, v.exp_cls};
    for (int t = 0; t < TMO + 40 && !seen; t++) begin
      @(negedge clk);
      if (m_tvalid) begin
        seen = 1'b1;
        vc   = cyc;
      end
    end
    check($sformatf("v%0d_emit_seen", id), seen, 1);
    if (v.en == 3'b111) check($sformatf("v%0d_latency", id), vc - hc, 2);
    else                check($sformatf("v%0d_tmo_latency", id), vc - ec, TMO + 1);
    check($sformatf("v%0d_tdata", id), m_tdata, exp_word);
    check($sformatf("v%0d_tkeep_tlast", id), {m_tkeep, m_tlast}, 5'h1F);
    check($sformatf("v%0d_err_timeout", id), err_timeout, v.exp_err);
    for (int k = 0; k < 3; k++) begin
      nerr = 0;
      check($sformatf("v%0d_clf%0d_count", id, k + 1), rxq[k].size(), NF);
      for (int w = 0; w < rxq[k].size(); w++) begin
        exp_rx = {(w == NF - 1), 4'(w), base + 32'(w)};
        if (rxq[k][w] !== exp_rx) nerr++;
      end
      check($sformatf("v%0d_clf%0d_words", id, k + 1), nerr, 0);
    end
    // Hold with downstream stalled, then accept and see valid drop.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_hold", id), {m_tvalid, m_tdata}, {1'b1, exp_word});
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_release", id), m_tvalid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ec;
    vec_t v;
    total = 0; bad = 0; rnd_mode = 1'b0;
    rst_n = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    res_tlast = '0;
    for (int k = 0; k < 3; k++) res_tdata[k] = '0;

    // Everything that could request a handshake is active during reset.
    s_tvalid = 1'b1; res_tvalid = 3'b111; m_tready = 1'b1;
    #12;
    check("reset_clf_tvalid", clf_tvalid, 0);
    check("reset_s_tready", s_tready, 0);
    check("reset_res_tready", res_tready, 0);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_err_timeout", err_timeout, 0);
    s_tvalid = 1'b0; res_tvalid = '0; m_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_tready", s_tready, 1);
    check("idle_outputs", {m_tvalid, clf_tvalid, clf_tlast, res_tready}, 0);
    @(posedge clk);
    #1;

    //          tlast gaps rnd  en      {c3,c2,c1}              class  top    err
    vecs[0] = '{15, 1'b0, 1'b0, 3'b111, {8'd5, 8'd5, 8'd5}, 8'd5, 8'h0F, 1'b0};
    vecs[1] = '{15, 1'b0, 1'b0, 3'b111, {8'd7, 8'd3, 8'd3}, 8'd3, 8'h07, 1'b0};
    vecs[2] = '{15, 1'b0, 1'b0, 3'b111, {8'd7, 8'd7, 8'd3}, 8'd7, 8'h07, 1'b0};
    vecs[3] = '{15, 1'b0, 1'b0, 3'b111, {8'd4, 8'd2, 8'd1}, 8'd1, 8'h17, 1'b0};
    vecs[4] = '{15, 1'b1, 1'b1, 3'b111, {8'd2, 8'd2, 8'd2}, 8'd2, 8'h0F, 1'b0};
    vecs[5] = '{ 9, 1'b0, 1'b0, 3'b111, {8'd1, 8'd8, 8'd8}, 8'd8, 8'h47, 1'b0};
    vecs[6] = '{15, 1'b0, 1'b0, 3'b011, {8'd0, 8'd9, 8'd9}, 8'd9, 8'h23, 1'b1};
    vecs[7] = '{15, 1'b0, 1'b0, 3'b111, {8'd6, 8'd6, 8'd6}, 8'd6, 8'h0F, 1'b1};
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a sample: six words taken, word 6 on offer.
    for (int k = 0; k < 3; k++) rxq[k].delete();
    feed(6, 15, 1'b0, 32'h9000, ec);
    check("partial_words", rxq[0].size(), 6);
    s_tdata = 32'h9006; s_tkeep = 4'h6; s_tvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_clf_tvalid", clf_tvalid, 0);
    check("midreset_s_tready", s_tready, 0);
    check("midreset_err_timeout", err_timeout, 0);
    check("midreset_m_res", {m_tvalid, res_tready}, 0);
    s_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{15, 1'b0, 1'b0, 3'b111, {8'd4, 8'd4, 8'd4}, 8'd4, 8'h0F, 1'b0};
    run_vec(8, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
